// File: rtl/apb_regfile_param.sv
// apb_regfile_param
//   Parametrised APB3 slave register file. Holds NUM_REGS word-spaced
//   registers starting at BASE_ADDR. Supports configurable wait states,
//   byte-lane write strobes, read-only registers fed by hardware (ro_in),
//   and PSLVERR on bad accesses. Register contents are exported flat on reg_q.
//
// Ports
//   pclk     in   APB clock, rising edge
//   preset   in   asynchronous active-high reset
//   psel     in   slave select
//   penable  in   access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address
//   pwdata   in   write data
//   pstrb    in   byte-lane write strobes
//   prdata   out  read data, non-zero only with pready
//   pready   out  one-cycle transfer-complete pulse
//   pslverr  out  error flag, qualified by pready
//   reg_q    out  flattened registers, reg i at [i*DATA_W +: DATA_W]
//   ro_in    in   hardware values for read-only registers
module apb_regfile_param #(
    parameter logic [31:0]         BASE_ADDR   = 32'h7000_0000,
    parameter int                  NUM_REGS    = 8,
    parameter int                  DATA_W      = 32,
    parameter int                  WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RST_VAL     = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [31:0]                  paddr,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_in
);

    localparam int          STRB_W      = DATA_W / 8;
    // Widened so a 6-bit index can address it without width mismatches.
    localparam logic [63:0] RO_MASK_EXT = 64'(RO_MASK);
    localparam logic [31:0] SPAN        = 32'(4 * NUM_REGS);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                capture, enter_done;

    logic [31:0]         addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [31:0]         off;
    logic [5:0]          idx;
    logic                addr_ok, err;
    logic [DATA_W-1:0]   rd_val;

    // Next-state logic. Only the IDLE->SETUP edge captures the request, so
    // later changes of paddr/pwdata/pstrb during the transfer are ignored.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        capture    = 1'b0;
        enter_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                // penable must be low here, so a master still holding
                // psel&penable after DONE cannot start a second transfer.
                if (psel && !penable) begin
                    state_d = S_SETUP;
                    capture = 1'b1;
                end
            end
            S_SETUP: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (penable) begin
                    state_d    = S_ACCESS;
                    wait_cnt_d = '0;
                end
            end
            S_ACCESS: begin
                if (psel && penable) begin
                    if (wait_cnt_q == 4'(WAIT_STATES)) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address decode on the captured request; the offset wraps at 32 bits so
    // addresses below BASE_ADDR land far out of range.
    always_comb begin
        off     = addr_q - BASE_ADDR;
        idx     = off[7:2];
        addr_ok = (off[1:0] == 2'b00) && (off < SPAN);
        err     = !addr_ok ||
                  (write_q && (RO_MASK_EXT[idx] || (strb_q == '0)));
        rd_val  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 6'(i)) begin
                rd_val = RO_MASK_EXT[i] ? ro_in[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            prdata     <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (capture) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
            pready  <= enter_done;
            pslverr <= enter_done && err;
            prdata  <= (enter_done && !err && !write_q) ? rd_val : '0;
        end
    end

    // Register storage; commits on the edge that enters DONE.
    // NOTE: the register array is built from flops with a defined reset
    // value, so it is reset like any other state (not a RAM macro).
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else if (enter_done && !err && write_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (idx == 6'(i) && strb_q[b] && !RO_MASK_EXT[i]) begin
                        regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read-only entries mirror ro_in directly; writable entries show storage.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = RO_MASK_EXT[i] ? ro_in[i*DATA_W +: DATA_W]
                                                       : regs_q[i];
        end
    end

endmodule

// File: tb/tb_apb_regfile_param.sv
// tb_apb_regfile_param
//   Three instances (WAIT_STATES 0, 1, 3) share the APB bus signals; each has
//   its own psel. Register 3 is read-only. A driver issues transfers and
//   pushes the predicted response; a monitor pops and compares on pready.
module tb_apb_regfile_param;

    localparam int          NDUT = 3;
    localparam int          NR   = 8;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h7000_0000;
    localparam logic [7:0]  RO   = 8'h08;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    logic                pclk = 1'b0;
    logic                preset;
    logic [NDUT-1:0]     psel_v;
    logic                penable, pwrite;
    logic [31:0]         paddr, pwdata;
    logic [3:0]          pstrb;
    logic [NR*DW-1:0]    ro_in;
    logic [DW-1:0]       prdata_v [NDUT];
    logic [NDUT-1:0]     pready_v, pslverr_v;
    logic [NR*DW-1:0]    reg_q_v  [NDUT];

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        apb_regfile_param #(
            .BASE_ADDR(BASE), .NUM_REGS(NR), .DATA_W(DW),
            .WAIT_STATES(ws_of(k)), .RO_MASK(RO), .RST_VAL(32'h0)
        ) u_dut (
            .pclk(pclk), .preset(preset), .psel(psel_v[k]), .penable(penable),
            .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
            .prdata(prdata_v[k]), .pready(pready_v[k]), .pslverr(pslverr_v[k]),
            .reg_q(reg_q_v[k]), .ro_in(ro_in)
        );
    end

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          k;
        logic [31:0] rdata;
        logic        err;
        int          ready_cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model: plain per-instance register arrays.
    logic [31:0] mreg [NDUT][NR];

    task automatic model_reset();
        for (int j = 0; j < NDUT; j++)
            for (int i = 0; i < NR; i++) mreg[j][i] = 32'h0;
    endtask

    task automatic model_access(input int k, input bit wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                output logic [31:0] rdata, output logic err);
        logic [31:0] off;
        int          i;
        bit          ok, ro;
        off   = addr - BASE;
        ok    = (off % 4 == 0) && (off / 4 < 32'(NR));
        i     = ok ? int'(off / 4) : 0;
        ro    = ok && RO[i];
        err   = !ok || (wr && (ro || strb == 4'h0));
        rdata = 32'h0;
        if (!err && wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mreg[k][i][8*b +: 8] = data[8*b +: 8];
        end
        if (!err && !wr) rdata = ro ? ro_in[32*i +: 32] : mreg[k][i];
    endtask

    task automatic check_regs();
        logic [31:0] e;
        for (int j = 0; j < NDUT; j++)
            for (int i = 0; i < NR; i++) begin
                e = RO[i] ? ro_in[32*i +: 32] : mreg[j][i];
                check($sformatf("reg_q[%0d][%0d]", j, i), 64'(reg_q_v[j][32*i +: 32]), 64'(e));
            end
    endtask

    // Monitor: any pready must match the head of the scoreboard; outside
    // pready, prdata and pslverr must stay low.
    always @(negedge pclk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (pready_v[k]) begin
                if (sb.size() == 0 || sb[0].k != k) begin
                    check($sformatf("spurious_pready[%0d]", k), 64'(pready_v[k]), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("prdata[%0d]", k),  64'(prdata_v[k]),  64'(e.rdata));
                    check($sformatf("pslverr[%0d]", k), 64'(pslverr_v[k]), 64'(e.err));
                    check($sformatf("latency[%0d]", k), 64'(cyc),          64'(e.ready_cyc));
                end
            end else begin
                check($sformatf("idle_out[%0d]", k), {31'h0, pslverr_v[k], prdata_v[k]}, 64'(0));
            end
        end
    end

    task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input bit hold);
        exp_t e;
        bit   seen;
        model_access(k, wr, addr, data, strb, e.rdata, e.err);
        e.k = k;
        @(posedge pclk); #1;
        psel_v[k] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge pclk); #1;
        penable     = 1'b1;
        e.ready_cyc = cyc + ws_of(k) + 2;
        sb.push_back(e);
        // Captured request must not be affected by later bus changes.
        pwrite = 1'($urandom); paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge pclk);
            if (pready_v[k]) seen = 1'b1;
        end
        check($sformatf("pready_seen[%0d]", k), 64'(seen), 64'(1));
        if (!seen) sb.delete();
        if (hold) repeat (3) @(posedge pclk);
        @(posedge pclk); #1;
        psel_v[k] = 1'b0; penable = 1'b0;
        check_regs();
    endtask

    task automatic reset_mid_write(input int k);
        @(posedge pclk); #1;
        psel_v[k] = 1'b1; penable = 1'b0;
        pwrite = 1'b1; paddr = BASE + 32'h8; pwdata = 32'h6170_6861; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #2;
        preset = 1'b1;
        model_reset();
        #1;
        for (int j = 0; j < NDUT; j++) begin
            check($sformatf("rst_pready[%0d]", j),  64'(pready_v[j]),  64'(0));
            check($sformatf("rst_prdata[%0d]", j),  64'(prdata_v[j]),  64'(0));
            check($sformatf("rst_pslverr[%0d]", j), 64'(pslverr_v[j]), 64'(0));
        end
        @(posedge pclk); #1;
        preset = 1'b0;
        repeat (6) @(posedge pclk);
        #1;
        psel_v[k] = 1'b0; penable = 1'b0;
        check_regs();
    endtask

    task automatic rand_xfer(input int k);
        logic [31:0] addr;
        logic [3:0]  strb;
        int          r;
        r = $urandom_range(0, 9);
        case (r)
            6:       addr = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
            7:       addr = BASE + 32'd32 + 32'(4 * $urandom_range(0, 20));
            8:       addr = BASE - 32'(4 * $urandom_range(1, 4));
            9:       addr = BASE + 32'hC;
            default: addr = BASE + 32'(4 * $urandom_range(0, 7));
        endcase
        strb = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        if ($urandom_range(0, 3) == 0) ro_in = {8{$urandom}};
        xfer(k, 1'($urandom), addr, $urandom, strb, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1; psel_v = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        ro_in = {8{$urandom}};
        ro_in[32*3 +: 32] = 32'hDEAD_BEEF;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        for (int j = 0; j < NDUT; j++) begin
            check($sformatf("reset_pready[%0d]", j), 64'(pready_v[j]), 64'(0));
            check($sformatf("reset_prdata[%0d]", j), 64'(prdata_v[j]), 64'(0));
        end
        check_regs();
        preset = 1'b0;

        for (int k = 0; k < NDUT; k++) begin
            xfer(k, 1, BASE,          32'h6,         4'hF, 0);
            xfer(k, 0, BASE,          32'h0,         4'h0, 0);
            xfer(k, 1, BASE + 32'h4,  32'h0B1407E9,  4'b0011, 0);
            xfer(k, 0, BASE + 32'h4,  32'h0,         4'hF, 0);
            xfer(k, 1, BASE + 32'h4,  32'h0B1407E9,  4'hF, 0);
            xfer(k, 0, BASE + 32'h4,  32'h0,         4'h0, 0);
            xfer(k, 1, BASE + 32'h20, 32'h1234_5678, 4'hF, 0);
            xfer(k, 0, BASE + 32'h2,  32'h0,         4'hF, 0);
            xfer(k, 1, BASE + 32'h1C, 32'hAAAA_5555, 4'h0, 0);
            xfer(k, 1, BASE + 32'hC,  32'h1111_2222, 4'hF, 0);
            xfer(k, 0, BASE + 32'hC,  32'h0,         4'hF, 0);
            xfer(k, 1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, 1);
            xfer(k, 0, BASE + 32'h10, 32'h0,         4'h0, 1);
        end

        reset_mid_write(2);

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NDUT; k++) rand_xfer(k);
        end

        repeat (5) @(posedge pclk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
